// File: rtl/test_result_monitor_pkg.sv
// Shared verdict encoding and default tohost location for the result monitor.
package test_result_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] WORD_MASK           = 32'hFFFF_FFFC;

  // Word-granular compare: byte offset within the tohost word is ignored.
  function automatic logic is_tohost(input logic [31:0] addr, input logic [31:0] tohost);
    return (addr & WORD_MASK) == (tohost & WORD_MASK);
  endfunction

endpackage

// File: rtl/test_result_monitor_if.sv
// Store/retire observation inputs and verdict outputs of the result monitor.
interface test_result_monitor_if;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        retire;
  logic [31:0] retire_pc;

  logic        done;
  logic        pass;
  logic        fail;
  logic [30:0] fail_test;
  logic        timeout;
  logic        hang;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  modport master (
    output dmem_we, dmem_addr, dmem_wdata, retire, retire_pc,
    input  done, pass, fail, fail_test, timeout, hang, cycle_count, retire_count
  );

  modport slave (
    input  dmem_we, dmem_addr, dmem_wdata, retire, retire_pc,
    output done, pass, fail, fail_test, timeout, hang, cycle_count, retire_count
  );
endinterface

// File: rtl/test_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX.
// Count visible the cycle after inc; no backpressure.
module sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/test_result_monitor.sv
// Watches tohost stores and the retire stream, latching a sticky pass/fail/timeout/hang verdict.
// Verdict registered one cycle after the deciding edge; purely observational, never stalls the core.
module test_result_monitor
  import test_result_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int          TIMEOUT     = 5000,
  parameter int          HANG_LIMIT  = 16
) (
  input logic                  clk,
  input logic                  rst,
  test_result_monitor_if.slave mon
);

  localparam int SW = $clog2(HANG_LIMIT + 1);

  state_t          state;
  logic [31:0]     cycle_cnt;
  logic [31:0]     retire_cnt;
  logic [SW-1:0]   same_cnt;
  logic [31:0]     last_pc;
  logic            pc_valid;

  logic run;
  logic hit;
  logic pc_match;
  logic repeat_retire;
  logic new_pc;
  logic hang_now;
  logic timeout_now;

  assign run           = (state == ST_RUN);
  assign hit           = run && mon.dmem_we && is_tohost(mon.dmem_addr, TOHOST_ADDR)
                         && (mon.dmem_wdata != 32'd0);
  // The first retire after reset only primes last_pc, so it can never match.
  assign pc_match      = pc_valid && (mon.retire_pc == last_pc);
  assign repeat_retire = run && mon.retire && pc_match;
  assign new_pc        = run && mon.retire && !pc_match;
  assign hang_now      = repeat_retire && (same_cnt == SW'(HANG_LIMIT - 1));
  assign timeout_now   = run && (cycle_cnt == 32'(TIMEOUT - 1));

  sat_counter #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  sat_counter #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (run && mon.retire),
    .clr   (1'b0),
    .count (retire_cnt)
  );

  sat_counter #(.WIDTH(SW), .MAX(SW'(HANG_LIMIT))) u_same_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (repeat_retire),
    .clr   (new_pc),
    .count (same_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_pc  <= '0;
      pc_valid <= 1'b0;
    end else if (new_pc) begin
      last_pc  <= mon.retire_pc;
      pc_valid <= 1'b1;
    end
  end

  // Priority: tohost hit beats hang beats timeout, since tests self-loop right after writing tohost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_RUN;
      mon.done      <= 1'b0;
      mon.pass      <= 1'b0;
      mon.fail      <= 1'b0;
      mon.fail_test <= '0;
      mon.timeout   <= 1'b0;
      mon.hang      <= 1'b0;
    end else if (state == ST_RUN) begin
      if (hit) begin
        mon.done <= 1'b1;
        if (mon.dmem_wdata == 32'd1) begin
          state    <= ST_PASS;
          mon.pass <= 1'b1;
        end else begin
          state         <= ST_FAIL;
          mon.fail      <= 1'b1;
          mon.fail_test <= mon.dmem_wdata[31:1];
        end
      end else if (hang_now) begin
        state       <= ST_HANG;
        mon.done    <= 1'b1;
        mon.timeout <= 1'b1;
        mon.hang    <= 1'b1;
      end else if (timeout_now) begin
        state       <= ST_TIMEOUT;
        mon.done    <= 1'b1;
        mon.timeout <= 1'b1;
      end
    end
  end

  assign mon.cycle_count  = cycle_cnt;
  assign mon.retire_count = retire_cnt;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed and randomized checks of test_result_monitor against a trace-based reference model.
module tb_test_result_monitor;

  localparam int          TO     = 300;
  localparam int          HL     = 4;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TO = 3, V_HANG = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  test_result_monitor_if bus();

  test_result_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT(TO), .HANG_LIMIT(HL)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: verdict, counters, and the list of PCs retired since reset.
  int          m_v;
  logic [30:0] m_ft;
  logic [31:0] m_cyc;
  logic [31:0] m_rc;
  logic [31:0] pcs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v   = V_RUN;
    m_ft  = '0;
    m_cyc = '0;
    m_rc  = '0;
    pcs.delete();
  endtask

  task automatic model_edge();
    int   tail;
    logic hitv;
    if (m_v != V_RUN) return;
    hitv = bus.dmem_we && ((bus.dmem_addr >> 2) == (TOHOST >> 2)) && (bus.dmem_wdata != 0);
    if (bus.retire) pcs.push_back(bus.retire_pc);
    // Length of the run of identical PCs at the end of the retire trace.
    tail = 0;
    if (pcs.size() > 0)
      for (int i = pcs.size() - 1; i >= 0 && pcs[i] == pcs[pcs.size()-1]; i--) tail++;
    if (hitv) begin
      if (bus.dmem_wdata == 1) m_v = V_PASS;
      else begin
        m_v  = V_FAIL;
        m_ft = bus.dmem_wdata[31:1];
      end
    end else if (bus.retire && tail >= HL + 1) m_v = V_HANG;
    else if (m_cyc + 1 == TO) m_v = V_TO;
    if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (bus.retire && m_rc != 32'hFFFF_FFFF) m_rc++;
  endtask

  task automatic check_model();
    chk("done",  32'(bus.done),    32'(m_v != V_RUN));
    chk("pass",  32'(bus.pass),    32'(m_v == V_PASS));
    chk("fail",  32'(bus.fail),    32'(m_v == V_FAIL));
    chk("tout",  32'(bus.timeout), 32'(m_v == V_TO || m_v == V_HANG));
    chk("hang",  32'(bus.hang),    32'(m_v == V_HANG));
    chk("ftest", 32'(bus.fail_test), 32'(m_ft));
    chk("cyc",   bus.cycle_count,  m_cyc);
    chk("rcnt",  bus.retire_count, m_rc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_fail"}, 32'(bus.fail), 0);
    chk({tag, "_ft"},   32'(bus.fail_test), 0);
    chk({tag, "_to"},   32'(bus.timeout), 0);
    chk({tag, "_hang"}, 32'(bus.hang), 0);
    chk({tag, "_cyc"},  bus.cycle_count, 0);
    chk({tag, "_rc"},   bus.retire_count, 0);
  endtask

  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic ret, input logic [31:0] pc);
    bus.dmem_we    = we;
    bus.dmem_addr  = addr;
    bus.dmem_wdata = wd;
    bus.retire     = ret;
    bus.retire_pc  = pc;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    bus.dmem_we = 1'b0;
    bus.retire  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wd);
    step(1, addr, wd, 0, 32'h0);
  endtask

  task automatic ret_pc(input logic [31:0] pc);
    step(0, 32'h0, 32'h0, 1, pc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    check_zero("rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #4;
    rst = 1'b1;
  endtask

  initial begin
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.retire     = 1'b0;
    bus.retire_pc  = '0;
    model_reset();
    #2;

    // PASS at cycle 100, verdict held afterwards
    do_reset();
    idle(100);
    store(32'h1000, 32'd1);
    chk("pass_flag", 32'(bus.pass), 1);
    chk("pass_cyc", bus.cycle_count, 101);
    for (int i = 0; i < 50; i++)
      step($urandom_range(1, 0), 32'h1000, $urandom, $urandom_range(1, 0), 32'h40);
    chk("pass_hold_cyc", bus.cycle_count, 101);

    // FAIL via byte address in the tohost word, later pass write ignored
    do_reset();
    idle(7);
    store(32'h1002, 32'h7);
    chk("fail_test3", 32'(bus.fail_test), 3);
    store(32'h1000, 32'd1);
    chk("fail_no_pass", 32'(bus.pass), 0);

    // TIMEOUT, then a hit on the timeout edge wins
    do_reset();
    idle(TO);
    chk("to_flag", 32'(bus.timeout), 1);
    chk("to_cyc", bus.cycle_count, TO);
    do_reset();
    idle(TO - 1);
    store(32'h1000, 32'd1);
    chk("to_hit_pass", 32'(bus.pass), 1);
    chk("to_hit_tout", 32'(bus.timeout), 0);

    // HANG after five retires at the same PC
    do_reset();
    ret_pc(32'h100);
    ret_pc(32'h104);
    for (int i = 0; i < 5; i++) ret_pc(32'h108);
    chk("hang_flag", 32'(bus.hang), 1);
    chk("hang_rc", bus.retire_count, 7);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ret_pc(32'h108);
      ret_pc(32'h10c);
    end
    chk("nohang", 32'(bus.done), 0);

    // hang and timeout on one edge, then hit and hang on one edge
    do_reset();
    idle(TO - 5);
    for (int i = 0; i < 5; i++) ret_pc(32'h300);
    chk("hang_over_to", 32'(bus.hang), 1);
    do_reset();
    for (int i = 0; i < 4; i++) ret_pc(32'h300);
    step(1, 32'h1000, 32'd1, 1, 32'h300);
    chk("hit_over_hang", 32'(bus.pass), 1);

    // ignored writes
    do_reset();
    store(32'h1000, 32'd0);
    store(32'h1004, 32'd1);
    chk("ignored", 32'(bus.done), 0);

    // async reset after PASS, then FAIL with code 5
    do_reset();
    idle(3);
    store(32'h1000, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("arst");
    model_reset();
    #2;
    rst = 1'b1;
    store(32'h1000, 32'd5);
    chk("arst_ft2", 32'(bus.fail_test), 2);

    // randomized runs against the model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 320; i++) begin
        logic [31:0] a, d, p;
        case ($urandom_range(3, 0))
          0: a = 32'h1000;
          1: a = 32'h1003;
          2: a = 32'h1004;
          default: a = $urandom;
        endcase
        case ($urandom_range(2, 0))
          0: d = 32'd0;
          1: d = 32'd1;
          default: d = $urandom;
        endcase
        p = ($urandom_range(9, 0) < 8) ? 32'h200 : 32'h204;
        step(($urandom_range(99, 0) < 2), a, d, ($urandom_range(9, 0) < 6), p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
